psram_fb_sched: RTL and testbench
=================================

PSRAM_FB_SCHED -- requirements
Module: psram_fb_sched

Interface
REQ-001 SHALL provide parameter ADDR_W, default 21, PSRAM word-address width (MSB = bank bit).
REQ-002 SHALL provide parameter LVL_W, default 9, FIFO level width.
REQ-003 SHALL provide parameter BURST, default 64, address increment per burst.
REQ-004 SHALL provide parameter WR_DATA_CYC, default 32, wrf_ren cycles per write burst.
REQ-005 SHALL provide parameter FRAME_LEN, default 393216, words per frame per bank.
REQ-006 SHALL provide parameter TCMD_GAP, default 50, minimum cycles between cmd_en pulses.
REQ-007 SHALL provide parameter WR_THRESH, default 64, wrf_level needed to request a write.
REQ-008 SHALL provide parameter RD_THRESH, default 64, rdf_level below which a read is requested.
REQ-009 SHALL provide parameter RD_TIMEOUT, default 255, cycles allowed for a read burst.
REQ-010 SHALL provide parameter PINGPONG, default 1, two-bank mode enable.
REQ-011 SHALL provide parameter FAIR, default 1: 1 = alternate on contention, 0 = write priority.
REQ-012 clk_use_psram  in  1  clock; all logic on rising edge.
REQ-013 sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-014 init_calib  in  1  PSRAM calibrated.
REQ-015 wr_load, rd_load  in  1 each  async frame-restart requests.
REQ-016 wrf_level, rdf_level  in  LVL_W each  write-FIFO read-side / read-FIFO write-side occupancy.
REQ-017 rd_data_valid  in  1  PSRAM read data valid.
REQ-018 cmd  out  1  1 = write, 0 = read.
REQ-019 cmd_en  out  1  one-cycle command strobe.
REQ-020 addr  out  ADDR_W  burst address.
REQ-021 wrf_ren  out  1  write-FIFO read enable.
REQ-022 wr_load_pulse, rd_load_pulse  out  1 each  synchronised rising-edge pulses, for FIFO flush.
REQ-023 wr_hold  out  1  writer finished frame, waiting for swap.
REQ-024 frame_swap  out  1  one-cycle bank-swap pulse.
REQ-025 rd_err  out  1  sticky read timeout.

Function
REQ-026 wr_load/rd_load SHALL pass 2-FF synchronisers; pulses assert one cycle on rising edge, 3 cycles after input rises.
REQ-027 FSM states IDLE, ARB, WR_DATA, RD_WAIT; IDLE->ARB when init_calib=1; init_calib=0 in any state forces IDLE after current burst completes.
REQ-028 Gap counter SHALL restart at every cmd_en; ARB issues only when counter >= TCMD_GAP and no burst is active.
REQ-029 wr_req = (wrf_level >= WR_THRESH) & ~wr_hold; rd_req = rdf_level < RD_THRESH.
REQ-030 Both requests with FAIR=1: grant type opposite to last grant; FAIR=0: write always.
REQ-031 On grant: cmd_en=1 for one cycle, cmd and addr valid same cycle, addr = {bank, offset}; cmd and addr held until next cmd_en.
REQ-032 WR_DATA: wrf_ren high exactly WR_DATA_CYC cycles starting cycle after cmd_en; then wr offset += BURST, ->ARB.
REQ-033 RD_WAIT: exits on rd_data_valid falling edge; rd offset += BURST, ->ARB.
REQ-034 RD_WAIT lasting RD_TIMEOUT cycles: set rd_err, ->ARB, offset unchanged.
REQ-035 Offset reaching FRAME_LEN-BURST and advancing = frame end; offset wraps to 0.
REQ-036 PINGPONG=1, writer frame end: wr_hold=1.
REQ-037 PINGPONG=1, reader frame end: if wr_hold, swap wr_bank/rd_bank, clear wr_hold, pulse frame_swap; else reader repeats same bank.
REQ-038 PINGPONG=0: both banks 0, wr_hold never set, offsets wrap independently.
REQ-039 wr_load_pulse: wr offset 0, wr_hold cleared, banks kept; rd_load_pulse: rd offset 0; either during a burst takes effect after burst completion; load beats concurrent frame-end update.

Reset
REQ-040 Reset: IDLE, cmd=0, cmd_en=0, addr=0, wrf_ren=0, pulses 0, wr_hold=0, frame_swap=0, rd_err=0, offsets 0, wr_bank=0, rd_bank=PINGPONG, gap counter saturated.

Structure
REQ-041 State encodings and defaults SHALL reside in package psram_fb_pkg.
REQ-042 Sub-module psram_load_sync (2-FF sync + edge detect) SHALL be instantiated twice.

Verification (BURST=4, FRAME_LEN=16, WR_DATA_CYC=2, TCMD_GAP=8, thresholds 4)
REQ-043 wrf_level=4, rdf_level=8 -> cmd_en, cmd=1, addr=0; wrf_ren cycles +1..+2; next write addr=4 no earlier than +8.
REQ-044 wrf_level=4, rdf_level=0, FAIR=1 -> write, read, write alternation; FAIR=0 -> writes only.
REQ-045 Four writes -> wr_hold=1; reader frame end -> frame_swap, wr_bank=1, rd_bank=0, next write addr={1,0}.
REQ-046 Read with rd_data_valid never rising -> rd_err after 255 cycles, read addr unchanged.
REQ-047 wr_load pulse mid-WR_DATA -> burst completes, next write addr bank|0, wr_hold=0.
REQ-048 Reset mid-RD_WAIT -> all outputs at REQ-040 values next cycle.

Source files
------------

// File: rtl/psram_fb_pkg.sv
// psram_fb_pkg: state encoding and parameter defaults for the PSRAM frame-buffer scheduler
package psram_fb_pkg;
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARB     = 2'd1,
      ST_WR_DATA = 2'd2,
      ST_RD_WAIT = 2'd3
   } fb_state_t;
   localparam int DEF_ADDR_W      = 21;
   localparam int DEF_LVL_W       = 9;
   localparam int DEF_BURST       = 64;
   localparam int DEF_WR_DATA_CYC = 32;
   localparam int DEF_FRAME_LEN   = 393216;
   localparam int DEF_TCMD_GAP    = 50;
   localparam int DEF_WR_THRESH   = 64;
   localparam int DEF_RD_THRESH   = 64;
   localparam int DEF_RD_TIMEOUT  = 255;
   localparam int DEF_PINGPONG    = 1;
   localparam int DEF_FAIR        = 1;
   // last grant treated as a read after reset, so the first contended grant is a write
   localparam logic LAST_WR_RST   = 1'b0;
endpackage

// File: rtl/psram_load_sync.sv
// psram_load_sync: 2-FF synchroniser for an async load request with a registered rising-edge pulse
module psram_load_sync
   import psram_fb_pkg::*;
(
   input  logic clk_use_psram,
   input  logic sys_rst_n,
   input  logic load_in,
   output logic load_pulse
);
   logic s1, s2, s3;
   // synchronise the request and emit one pulse, three cycles after the input rises
   always_ff @(posedge clk_use_psram or negedge sys_rst_n)
      if (!sys_rst_n) begin
         {s1, s2, s3, load_pulse} <= '0;
      end else begin
         s1         <= load_in;
         s2         <= s1;
         s3         <= s2;
         load_pulse <= s2 & ~s3;
      end
endmodule

// File: rtl/psram_fb_sched.sv
// psram_fb_sched: arbitrates write/read bursts to PSRAM with ping-pong frame banks
module psram_fb_sched
   import psram_fb_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int LVL_W       = DEF_LVL_W,
   parameter int BURST       = DEF_BURST,
   parameter int WR_DATA_CYC = DEF_WR_DATA_CYC,
   parameter int FRAME_LEN   = DEF_FRAME_LEN,
   parameter int TCMD_GAP    = DEF_TCMD_GAP,
   parameter int WR_THRESH   = DEF_WR_THRESH,
   parameter int RD_THRESH   = DEF_RD_THRESH,
   parameter int RD_TIMEOUT  = DEF_RD_TIMEOUT,
   parameter int PINGPONG    = DEF_PINGPONG,
   parameter int FAIR        = DEF_FAIR
) (
   input  logic              clk_use_psram,
   input  logic              sys_rst_n,
   input  logic              init_calib,
   input  logic              wr_load,
   input  logic              rd_load,
   input  logic [LVL_W-1:0]  wrf_level,
   input  logic [LVL_W-1:0]  rdf_level,
   input  logic              rd_data_valid,
   output logic              cmd,
   output logic              cmd_en,
   output logic [ADDR_W-1:0] addr,
   output logic              wrf_ren,
   output logic              wr_load_pulse,
   output logic              rd_load_pulse,
   output logic              wr_hold,
   output logic              frame_swap,
   output logic              rd_err
);
   localparam int OFF_W = ADDR_W - 1;
   localparam int GAP_W = $clog2(TCMD_GAP + 1);
   localparam int DAT_W = $clog2(WR_DATA_CYC + 1);
   localparam int TMO_W = $clog2(RD_TIMEOUT + 1);
   localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(TCMD_GAP);
   localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(FRAME_LEN - BURST);
   localparam logic [OFF_W-1:0] OFF_STEP = OFF_W'(BURST);
   localparam logic PP = PINGPONG != 0;

   fb_state_t        state;
   logic [GAP_W-1:0] gap_cnt;
   logic [DAT_W-1:0] dat_cnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic [OFF_W-1:0] wr_off, rd_off;
   logic wr_bank, rd_bank, last_wr, rdv_q, wr_pend, rd_pend;
   logic wr_req, rd_req, idle_arb, wr_done, rd_done, rd_tmo;
   logic wr_pend_n, rd_pend_n, wr_apply, rd_apply, grant, grant_wr, wr_end, rd_end;

   psram_load_sync u_wr_sync (
      .clk_use_psram (clk_use_psram),
      .sys_rst_n     (sys_rst_n),
      .load_in       (wr_load),
      .load_pulse    (wr_load_pulse)
   );

   psram_load_sync u_rd_sync (
      .clk_use_psram (clk_use_psram),
      .sys_rst_n     (sys_rst_n),
      .load_in       (rd_load),
      .load_pulse    (rd_load_pulse)
   );

   // request, grant and burst-completion decode; a pending load blocks grants until applied
   always_comb begin
      wr_req    = (wrf_level >= LVL_W'(WR_THRESH)) & ~wr_hold;
      rd_req    = rdf_level < LVL_W'(RD_THRESH);
      wr_pend_n = wr_pend | wr_load_pulse;
      rd_pend_n = rd_pend | rd_load_pulse;
      idle_arb  = (state == ST_IDLE) | (state == ST_ARB);
      wr_done   = (state == ST_WR_DATA) & (dat_cnt == DAT_W'(WR_DATA_CYC));
      rd_done   = (state == ST_RD_WAIT) & rdv_q & ~rd_data_valid;
      rd_tmo    = (state == ST_RD_WAIT) & ~rd_done & (tmo_cnt == TMO_W'(RD_TIMEOUT - 1));
      wr_apply  = wr_pend_n & (idle_arb | wr_done);
      rd_apply  = rd_pend_n & (idle_arb | rd_done | rd_tmo);
      grant     = (state == ST_ARB) & init_calib & (gap_cnt >= GAP_MAX) & (wr_req | rd_req)
                  & ~wr_pend_n & ~rd_pend_n;
      grant_wr  = wr_req & (~rd_req | (FAIR == 0) | ~last_wr);
      wr_end    = wr_off == OFF_LAST;
      rd_end    = rd_off == OFF_LAST;
   end

   // scheduler FSM with offsets, banks, flags and registered command outputs
   always_ff @(posedge clk_use_psram or negedge sys_rst_n)
      if (!sys_rst_n) begin
         state      <= ST_IDLE;
         cmd        <= 1'b0;
         cmd_en     <= 1'b0;
         addr       <= '0;
         wrf_ren    <= 1'b0;
         wr_hold    <= 1'b0;
         frame_swap <= 1'b0;
         rd_err     <= 1'b0;
         wr_off     <= '0;
         rd_off     <= '0;
         wr_bank    <= 1'b0;
         rd_bank    <= PP;
         last_wr    <= LAST_WR_RST;
         gap_cnt    <= GAP_MAX;
         dat_cnt    <= '0;
         tmo_cnt    <= '0;
         rdv_q      <= 1'b0;
         wr_pend    <= 1'b0;
         rd_pend    <= 1'b0;
      end else begin
         cmd_en     <= 1'b0;
         frame_swap <= 1'b0;
         rdv_q      <= rd_data_valid;
         wr_pend    <= wr_pend_n & ~wr_apply;
         rd_pend    <= rd_pend_n & ~rd_apply;
         if (gap_cnt < GAP_MAX) gap_cnt <= gap_cnt + 1'b1;
         if (wr_apply) begin
            wr_off  <= '0;
            wr_hold <= 1'b0;
         end else if (wr_done) begin
            wr_off <= wr_end ? '0 : wr_off + OFF_STEP;
            if (wr_end & PP) wr_hold <= 1'b1;
         end
         if (rd_apply) begin
            rd_off <= '0;
         end else if (rd_done) begin
            rd_off <= rd_end ? '0 : rd_off + OFF_STEP;
            if (rd_end & PP & wr_hold) begin
               wr_bank    <= rd_bank;
               rd_bank    <= wr_bank;
               wr_hold    <= 1'b0;
               frame_swap <= 1'b1;
            end
         end
         if (rd_tmo) rd_err <= 1'b1;
         case (state)
            ST_IDLE: if (init_calib) state <= ST_ARB;
            ST_ARB: begin
               if (!init_calib) begin
                  state <= ST_IDLE;
               end else if (grant) begin
                  cmd_en  <= 1'b1;
                  cmd     <= grant_wr;
                  addr    <= grant_wr ? {wr_bank, wr_off} : {rd_bank, rd_off};
                  last_wr <= grant_wr;
                  gap_cnt <= GAP_W'(1);
                  dat_cnt <= '0;
                  tmo_cnt <= '0;
                  state   <= grant_wr ? ST_WR_DATA : ST_RD_WAIT;
               end
            end
            ST_WR_DATA: begin
               wrf_ren <= ~wr_done;
               dat_cnt <= dat_cnt + 1'b1;
               if (wr_done) state <= init_calib ? ST_ARB : ST_IDLE;
            end
            ST_RD_WAIT: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (rd_done | rd_tmo) state <= init_calib ? ST_ARB : ST_IDLE;
            end
         endcase
      end
endmodule

// File: tb/tb_psram_fb_sched.sv
// tb_psram_fb_sched: directed scenario tests for the PSRAM frame-buffer scheduler
module tb_psram_fb_sched;
   localparam int AW = 8;

   logic clk_use_psram = 1'b0;
   logic sys_rst_n = 1'b0, init_calib = 1'b0, wr_load = 1'b0, rd_load = 1'b0, rd_data_valid = 1'b0;
   logic [8:0] wrf_level = '0, rdf_level = '0;
   logic cmd, cmd_en, wrf_ren, wr_load_pulse, rd_load_pulse, wr_hold, frame_swap, rd_err;
   logic [AW-1:0] addr;
   logic f0_cmd, f0_cmd_en, f0_wrf_ren, f0_wlp, f0_rlp, f0_wr_hold, f0_frame_swap, f0_rd_err;
   logic [AW-1:0] f0_addr;

   int total = 0, bad = 0, cyc = 0, rv_cnt = 0, swaps = 0;
   bit auto_rd = 1'b0;
   logic          log_cmd[$];
   logic [AW-1:0] log_addr[$];
   logic          f0_log_cmd[$];
   logic [AW-1:0] f0_log_addr[$];

   psram_fb_sched #(.ADDR_W(AW), .LVL_W(9), .BURST(4), .WR_DATA_CYC(2), .FRAME_LEN(16),
      .TCMD_GAP(8), .WR_THRESH(4), .RD_THRESH(4), .RD_TIMEOUT(255), .PINGPONG(1), .FAIR(1)) dut (
      .clk_use_psram(clk_use_psram), .sys_rst_n(sys_rst_n), .init_calib(init_calib),
      .wr_load(wr_load), .rd_load(rd_load), .wrf_level(wrf_level), .rdf_level(rdf_level),
      .rd_data_valid(rd_data_valid), .cmd(cmd), .cmd_en(cmd_en), .addr(addr), .wrf_ren(wrf_ren),
      .wr_load_pulse(wr_load_pulse), .rd_load_pulse(rd_load_pulse), .wr_hold(wr_hold),
      .frame_swap(frame_swap), .rd_err(rd_err));

   psram_fb_sched #(.ADDR_W(AW), .LVL_W(9), .BURST(4), .WR_DATA_CYC(2), .FRAME_LEN(16),
      .TCMD_GAP(8), .WR_THRESH(4), .RD_THRESH(4), .RD_TIMEOUT(255), .PINGPONG(1), .FAIR(0)) dut_f0 (
      .clk_use_psram(clk_use_psram), .sys_rst_n(sys_rst_n), .init_calib(init_calib),
      .wr_load(wr_load), .rd_load(rd_load), .wrf_level(wrf_level), .rdf_level(rdf_level),
      .rd_data_valid(rd_data_valid), .cmd(f0_cmd), .cmd_en(f0_cmd_en), .addr(f0_addr),
      .wrf_ren(f0_wrf_ren), .wr_load_pulse(f0_wlp), .rd_load_pulse(f0_rlp), .wr_hold(f0_wr_hold),
      .frame_swap(f0_frame_swap), .rd_err(f0_rd_err));

   always #5 clk_use_psram = ~clk_use_psram;

   // count rising edges so negedge samples can be timed against cmd_en
   always @(posedge clk_use_psram) cyc <= cyc + 1;

   // advance to the next negedge, log commands and answer reads with a two-cycle valid pulse
   task automatic step();
      @(negedge clk_use_psram);
      if (cmd_en) begin
         log_cmd.push_back(cmd);
         log_addr.push_back(addr);
      end
      if (f0_cmd_en) begin
         f0_log_cmd.push_back(f0_cmd);
         f0_log_addr.push_back(f0_addr);
      end
      if (frame_swap) swaps++;
      if (auto_rd && cmd_en && !cmd) begin
         rd_data_valid = 1'b1;
         rv_cnt = 2;
      end else if (rv_cnt > 0) begin
         rv_cnt--;
         if (rv_cnt == 0) rd_data_valid = 1'b0;
      end
   endtask

   task automatic clear_logs();
      log_cmd.delete();
      log_addr.delete();
      f0_log_cmd.delete();
      f0_log_addr.delete();
      swaps = 0;
   endtask

   task automatic do_reset();
      sys_rst_n = 1'b0;
      init_calib = 1'b0;
      wr_load = 1'b0;
      rd_load = 1'b0;
      rd_data_valid = 1'b0;
      wrf_level = '0;
      rdf_level = '0;
      auto_rd = 1'b0;
      rv_cnt = 0;
      repeat (3) @(negedge clk_use_psram);
      clear_logs();
      sys_rst_n = 1'b1;
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0;
      init_calib = 1'b1;
      wrf_level = 9'd4;
      repeat (3) @(negedge clk_use_psram);
      total++;
      if ({cmd, cmd_en, addr, wrf_ren, wr_load_pulse, rd_load_pulse, wr_hold, frame_swap, rd_err} !== '0)
         begin bad++; $display("FAIL reset_outputs got=%h exp=0", {cmd, cmd_en, addr, wrf_ren,
            wr_load_pulse, rd_load_pulse, wr_hold, frame_swap, rd_err}); end
      total++;
      if ({f0_cmd, f0_cmd_en, f0_addr, f0_wrf_ren, f0_wlp, f0_rlp, f0_wr_hold, f0_frame_swap, f0_rd_err} !== '0)
         begin bad++; $display("FAIL reset_outputs_f0 got=%h exp=0", {f0_cmd, f0_cmd_en, f0_addr,
            f0_wrf_ren, f0_wlp, f0_rlp, f0_wr_hold, f0_frame_swap, f0_rd_err}); end
   endtask

   task automatic test_write_basic();
      int n, rel, t0, d;
      do_reset();
      init_calib = 1'b1;
      wrf_level = 9'd4;
      rdf_level = 9'd8;
      rel = cyc;
      n = 0;
      while (log_cmd.size() < 1 && n < 20) begin step(); n++; end
      total++;
      if (log_cmd.size() < 1) begin bad++; $display("FAIL wr_first got=none exp=cmd_en"); return; end
      t0 = cyc;
      total++;
      if (t0 - rel !== 2) begin bad++; $display("FAIL wr_first_latency got=%0d exp=2", t0 - rel); end
      total++;
      if ({log_cmd[0], log_addr[0]} !== {1'b1, 8'h00})
         begin bad++; $display("FAIL wr_first_cmd got=%h exp=100", {log_cmd[0], log_addr[0]}); end
      step();
      total++;
      if ({cmd_en, wrf_ren} !== 2'b01) begin bad++; $display("FAIL wrf_ren_p1 got=%b exp=01", {cmd_en, wrf_ren}); end
      step();
      total++;
      if ({cmd_en, wrf_ren} !== 2'b01) begin bad++; $display("FAIL wrf_ren_p2 got=%b exp=01", {cmd_en, wrf_ren}); end
      step();
      total++;
      if (wrf_ren !== 1'b0) begin bad++; $display("FAIL wrf_ren_p3 got=%b exp=0", wrf_ren); end
      n = 0;
      while (log_cmd.size() < 2 && n < 20) begin step(); n++; end
      total++;
      if (log_cmd.size() < 2) begin bad++; $display("FAIL wr_second got=none exp=cmd_en"); return; end
      d = cyc - t0;
      total++;
      if (d < 8 || d > 9) begin bad++; $display("FAIL wr_gap got=%0d exp=8..9", d); end
      total++;
      if ({log_cmd[1], log_addr[1]} !== {1'b1, 8'h04})
         begin bad++; $display("FAIL wr_second_cmd got=%h exp=104", {log_cmd[1], log_addr[1]}); end
   endtask

   task automatic test_fair();
      logic [8:0] exp_f1 [3] = '{9'h100, 9'h080, 9'h104};
      logic [8:0] exp_f0 [3] = '{9'h100, 9'h104, 9'h108};
      do_reset();
      init_calib = 1'b1;
      wrf_level = 9'd4;
      rdf_level = 9'd0;
      auto_rd = 1'b1;
      repeat (30) step();
      total++;
      if (log_cmd.size() < 3 || f0_log_cmd.size() < 3) begin
         bad++; $display("FAIL fair_count got=%0d/%0d exp=3/3", log_cmd.size(), f0_log_cmd.size());
         return;
      end
      for (int i = 0; i < 3; i++) begin
         total++;
         if ({log_cmd[i], log_addr[i]} !== exp_f1[i])
            begin bad++; $display("FAIL fair1_cmd%0d got=%h exp=%h", i, {log_cmd[i], log_addr[i]}, exp_f1[i]); end
         total++;
         if ({f0_log_cmd[i], f0_log_addr[i]} !== exp_f0[i])
            begin bad++; $display("FAIL fair0_cmd%0d got=%h exp=%h", i, {f0_log_cmd[i], f0_log_addr[i]}, exp_f0[i]); end
      end
   endtask

   task automatic test_pingpong();
      logic [8:0] exp_rd [6] = '{9'h080, 9'h084, 9'h088, 9'h08c, 9'h180, 9'h000};
      do_reset();
      init_calib = 1'b1;
      wrf_level = 9'd4;
      rdf_level = 9'd8;
      auto_rd = 1'b1;
      repeat (40) step();
      total++;
      if (log_cmd.size() !== 4) begin bad++; $display("FAIL pp_writes got=%0d exp=4", log_cmd.size()); end
      for (int i = 0; i < 4 && i < log_cmd.size(); i++) begin
         total++;
         if ({log_cmd[i], log_addr[i]} !== {1'b1, 8'(4 * i)})
            begin bad++; $display("FAIL pp_wr%0d got=%h exp=%h", i, {log_cmd[i], log_addr[i]}, {1'b1, 8'(4 * i)}); end
      end
      total++;
      if (wr_hold !== 1'b1) begin bad++; $display("FAIL pp_hold_set got=%b exp=1", wr_hold); end
      clear_logs();
      rdf_level = 9'd0;
      repeat (50) step();
      total++;
      if (log_cmd.size() < 6) begin bad++; $display("FAIL pp_seq_len got=%0d exp>=6", log_cmd.size()); return; end
      for (int i = 0; i < 6; i++) begin
         total++;
         if ({log_cmd[i], log_addr[i]} !== exp_rd[i])
            begin bad++; $display("FAIL pp_seq%0d got=%h exp=%h", i, {log_cmd[i], log_addr[i]}, exp_rd[i]); end
      end
      total++;
      if (swaps !== 1) begin bad++; $display("FAIL pp_swaps got=%0d exp=1", swaps); end
      total++;
      if (wr_hold !== 1'b0) begin bad++; $display("FAIL pp_hold_clr got=%b exp=0", wr_hold); end
   endtask

   task automatic test_timeout();
      int n, t0;
      do_reset();
      init_calib = 1'b1;
      n = 0;
      while (log_cmd.size() < 1 && n < 20) begin step(); n++; end
      total++;
      if (log_cmd.size() < 1) begin bad++; $display("FAIL to_first got=none exp=cmd_en"); return; end
      t0 = cyc;
      total++;
      if ({log_cmd[0], log_addr[0]} !== {1'b0, 8'h80})
         begin bad++; $display("FAIL to_first_cmd got=%h exp=080", {log_cmd[0], log_addr[0]}); end
      n = 0;
      while (!rd_err && n < 300) begin step(); n++; end
      total++;
      if (rd_err !== 1'b1) begin bad++; $display("FAIL to_err got=%b exp=1", rd_err); return; end
      total++;
      if (cyc - t0 !== 255) begin bad++; $display("FAIL to_latency got=%0d exp=255", cyc - t0); end
      n = 0;
      while (log_cmd.size() < 2 && n < 10) begin step(); n++; end
      total++;
      if (log_cmd.size() < 2) begin bad++; $display("FAIL to_retry got=none exp=cmd_en"); return; end
      total++;
      if ({log_cmd[1], log_addr[1]} !== {1'b0, 8'h80})
         begin bad++; $display("FAIL to_retry_cmd got=%h exp=080", {log_cmd[1], log_addr[1]}); end
      step();
   endtask

   task automatic test_reset_mid_read();
      total++;
      if ({rd_err, cmd, addr} !== {1'b1, 1'b0, 8'h80})
         begin bad++; $display("FAIL rst_pre got=%h exp=280", {rd_err, cmd, addr}); end
      sys_rst_n = 1'b0;
      #1;
      total++;
      if ({cmd, cmd_en, addr, wrf_ren, wr_load_pulse, rd_load_pulse, wr_hold, frame_swap, rd_err} !== '0)
         begin bad++; $display("FAIL rst_mid_read got=%h exp=0", {cmd, cmd_en, addr, wrf_ren,
            wr_load_pulse, rd_load_pulse, wr_hold, frame_swap, rd_err}); end
   endtask

   task automatic test_load();
      int n, t0, cnt;
      do_reset();
      init_calib = 1'b1;
      wrf_level = 9'd4;
      rdf_level = 9'd8;
      n = 0;
      while (log_cmd.size() < 1 && n < 20) begin step(); n++; end
      total++;
      if (log_cmd.size() < 1) begin bad++; $display("FAIL ld_first got=none exp=cmd_en"); return; end
      t0 = cyc;
      while (cyc < t0 + 14) step();
      wr_load = 1'b1;
      step();
      step();
      total++;
      if ({log_cmd.size() == 3, wr_load_pulse} !== 2'b10)
         begin bad++; $display("FAIL ld_third_cmd got=%b exp=10", {log_cmd.size() == 3, wr_load_pulse}); end
      step();
      total++;
      if ({wr_load_pulse, wrf_ren} !== 2'b11)
         begin bad++; $display("FAIL ld_pulse_mid got=%b exp=11", {wr_load_pulse, wrf_ren}); end
      wr_load = 1'b0;
      step();
      total++;
      if ({wr_load_pulse, wrf_ren} !== 2'b01)
         begin bad++; $display("FAIL ld_pulse_end got=%b exp=01", {wr_load_pulse, wrf_ren}); end
      while (cyc < t0 + 26) step();
      total++;
      if (log_cmd.size() < 4) begin bad++; $display("FAIL ld_next got=%0d exp=4", log_cmd.size()); return; end
      total++;
      if ({log_cmd[2], log_addr[2], log_cmd[3], log_addr[3]} !== {1'b1, 8'h08, 1'b1, 8'h00})
         begin bad++; $display("FAIL ld_addrs got=%h exp=108100", {log_cmd[2], log_addr[2], log_cmd[3], log_addr[3]}); end
      while (cyc < t0 + 56) step();
      total++;
      if (wr_hold !== 1'b1) begin bad++; $display("FAIL ld_hold_set got=%b exp=1", wr_hold); end
      clear_logs();
      wr_load = 1'b1;
      rd_load = 1'b1;
      cnt = 0;
      repeat (8) begin step(); cnt += int'(rd_load_pulse); end
      wr_load = 1'b0;
      rd_load = 1'b0;
      total++;
      if (cnt !== 1) begin bad++; $display("FAIL ld_rd_pulse_width got=%0d exp=1", cnt); end
      total++;
      if (wr_hold !== 1'b0) begin bad++; $display("FAIL ld_hold_clr got=%b exp=0", wr_hold); end
      total++;
      if (log_cmd.size() < 1) begin bad++; $display("FAIL ld_resume got=none exp=cmd_en"); return; end
      total++;
      if ({log_cmd[0], log_addr[0]} !== {1'b1, 8'h00})
         begin bad++; $display("FAIL ld_resume_cmd got=%h exp=100", {log_cmd[0], log_addr[0]}); end
   endtask

   // run every scenario in sequence, then report
   initial begin
      test_reset();
      test_write_basic();
      test_fair();
      test_pingpong();
      test_load();
      test_timeout();
      test_reset_mid_read();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
